// File: rtl/mem_read_arbiter_if.sv
// Bus bundle for mem_read_arbiter: requester handshake, shared response
// path and the memory read-port signals.
// The slave modport is the arbiter's view; the master modport is the
// environment (requesters plus memory) driving it.
interface mem_read_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]       rsp_data;
    logic [ADDR_WIDTH-1:0]       mem_r_addr;
    logic                        mem_r_avalid;
    logic                        mem_r_dvalid;
    logic [DATA_WIDTH-1:0]       mem_r_data;

    modport slave (
        input  req_valid, req_addr, mem_r_dvalid, mem_r_data,
        output req_ready, rsp_valid, rsp_data, mem_r_addr, mem_r_avalid
    );

    modport master (
        output req_valid, req_addr, mem_r_dvalid, mem_r_data,
        input  req_ready, rsp_valid, rsp_data, mem_r_addr, mem_r_avalid
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one memory read port among
// N_REQ requesters. Every accepted request pushes its requester index into
// a tag FIFO; each returning word pops the head tag and is steered back to
// that requester as a one-hot rsp_valid.
// Optional macro MEM_RD_ARB_STATS_EN adds grant/stall statistics counters.
module mem_read_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_LAT   = 2,
    parameter int MAX_OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_read_arbiter_if.slave bus,
    output logic              err_orphan
`ifdef MEM_RD_ARB_STATS_EN
    ,
    output logic [31:0]       stat_grant_cnt,
    output logic [31:0]       stat_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    generate
        if (DATA_LAT < 1 || MAX_OUTST < 2 || N_REQ < 2 || N_REQ > 16) begin : g_bad_cfg
            $error("mem_read_arbiter: unsupported parameter combination");
        end
    endgenerate

    // Tag FIFO pointers advance modulo the FIFO depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decodes a requester index into its one-hot response lane.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] tag_mem [MAX_OUTST];

    logic             grant_vld_p0;
    logic [IDX_W-1:0] grant_idx_p0;
    logic             pop_p0;
    logic             orphan_p0;
    logic [IDX_W-1:0] head_tag_p0;

    // ---- stage p0: arbitration and FIFO bookkeeping (combinational) ----

    // Round-robin search from rr_ptr; scanning offsets downward lets the
    // smallest offset with a valid request overwrite the others.
    always_comb begin
        int cand;
        cand         = 0;
        grant_vld_p0 = 1'b0;
        grant_idx_p0 = '0;
        if (!rst && (fifo_cnt < CNT_W'(MAX_OUTST))) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                cand = (int'(rr_ptr) + k) % N_REQ;
                if (bus.req_valid[cand]) begin
                    grant_vld_p0 = 1'b1;
                    grant_idx_p0 = IDX_W'(cand);
                end
            end
        end
    end

    // Ready is the winner's lane only; zero when nothing is granted.
    always_comb begin
        bus.req_ready = '0;
        if (grant_vld_p0) begin
            bus.req_ready = idx_onehot(grant_idx_p0);
        end
    end

    // Returns pop only when a tag is outstanding; otherwise they are orphans.
    always_comb begin
        pop_p0      = bus.mem_r_dvalid && (fifo_cnt != '0);
        orphan_p0   = bus.mem_r_dvalid && (fifo_cnt == '0);
        head_tag_p0 = tag_mem[rd_ptr];
    end

    // ---- stage p1: registered issue, FIFO state and responses ----

    // Arbitration pointer, FIFO pointers/count and the memory issue port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr           <= '0;
            fifo_cnt         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.mem_r_avalid <= 1'b0;
            bus.mem_r_addr   <= '0;
        end else begin
            bus.mem_r_avalid <= grant_vld_p0;
            if (grant_vld_p0) begin
                rr_ptr         <= (grant_idx_p0 == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_p0 + 1'b1;
                bus.mem_r_addr <= bus.req_addr[grant_idx_p0*ADDR_WIDTH +: ADDR_WIDTH];
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop_p0) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({grant_vld_p0, pop_p0})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Tag storage is pure data; stale entries are never read after reset.
    always_ff @(posedge clk) begin
        if (grant_vld_p0) begin
            tag_mem[wr_ptr] <= grant_idx_p0;
        end
    end

    // Steer each returning word to the requester at the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= pop_p0 ? idx_onehot(head_tag_p0) : '0;
            if (pop_p0) begin
                bus.rsp_data <= bus.mem_r_data;
            end
        end
    end

    // Sticky flag for data returning with no outstanding tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (orphan_p0) begin
            err_orphan <= 1'b1;
        end
    end

`ifdef MEM_RD_ARB_STATS_EN
    // Free-running grant and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (grant_vld_p0) begin
                stat_grant_cnt <= stat_grant_cnt + 32'd1;
            end
            if ((|bus.req_valid) && !grant_vld_p0) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
// A variable-latency memory model sits on the read port.
// Build with MEM_RD_ARB_STATS_EN defined to also check the statistics.
module tb_mem_read_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LAT = 2;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_orphan;
`ifdef MEM_RD_ARB_STATS_EN
    logic [31:0] stat_grant_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_read_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_LAT(LAT), .MAX_OUTST(MO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_orphan(err_orphan)
`ifdef MEM_RD_ARB_STATS_EN
        ,
        .stat_grant_cnt(stat_grant_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    // Memory: contents array plus a valid/data delay line with selectable tap.
    logic [DW-1:0] mem [16];
    logic          pv [8];
    logic [DW-1:0] pd [8];
    int            mem_lat = 2;
    logic          inj = 1'b0;
    logic [DW-1:0] inj_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= bus.mem_r_avalid;
            pd[0] <= mem[bus.mem_r_addr];
            for (int k = 1; k < 8; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    assign bus.mem_r_dvalid = inj | pv[mem_lat-1];
    assign bus.mem_r_data   = inj ? inj_data : pd[mem_lat-1];

    // Reference model state.
    int            rr_m;
    int            tagq[$];
    logic [DW-1:0] dataq[$];
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    logic          exp_av;
    logic [AW-1:0] exp_ad;
    logic          exp_orph;
    int            gcnt;
    int            scnt;
    logic [N-1:0]  obs_ready;
    bit            auto_mode;
    int            total;
    int            bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        rr_m = 0;
        tagq.delete();
        dataq.delete();
        exp_rv = '0;
        exp_rd = '0;
        exp_av = 1'b0;
        exp_ad = '0;
        exp_orph = 1'b0;
        gcnt = 0;
        scnt = 0;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, then release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        chk("rst_avalid", 64'(bus.mem_r_avalid), 64'(0));
        chk("rst_raddr", 64'(bus.mem_r_addr), 64'(0));
        chk("rst_err_orphan", 64'(err_orphan), 64'(0));
`ifdef MEM_RD_ARB_STATS_EN
        chk("rst_stat_grant", 64'(stat_grant_cnt), 64'(0));
        chk("rst_stat_stall", 64'(stat_stall_cnt), 64'(0));
`endif
        bus.req_valid = '0;
        inj = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: check DUT against model at negedge, advance model, then
    // optionally refresh random requests after the edge.
    task automatic cycle();
        int win;
        logic [N-1:0]    v;
        logic [N*AW-1:0] a;
        logic            dv;
        logic [N-1:0]    er;
        @(negedge clk);
        v  = bus.req_valid;
        a  = bus.req_addr;
        dv = bus.mem_r_dvalid;
        win = -1;
        if (tagq.size() < MO) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && v[(rr_m + k) % N]) win = (rr_m + k) % N;
            end
        end
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        obs_ready = bus.req_ready;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("mem_r_avalid", 64'(bus.mem_r_avalid), 64'(exp_av));
        chk("mem_r_addr", 64'(bus.mem_r_addr), 64'(exp_ad));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv != '0) chk("rsp_data", 64'(bus.rsp_data), 64'(exp_rd));
        chk("err_orphan", 64'(err_orphan), 64'(exp_orph));
        exp_rv = '0;
        if (dv) begin
            if (tagq.size() > 0) begin
                exp_rv[tagq.pop_front()] = 1'b1;
                exp_rd = dataq.pop_front();
            end else begin
                exp_orph = 1'b1;
            end
        end
        if (win >= 0) begin
            tagq.push_back(win);
            dataq.push_back(mem[a[win*AW +: AW]]);
            rr_m   = (win + 1) % N;
            exp_av = 1'b1;
            exp_ad = a[win*AW +: AW];
            gcnt++;
        end else begin
            exp_av = 1'b0;
            if (|v) scnt++;
        end
        @(posedge clk);
        #1;
        if (auto_mode) begin
            for (int i = 0; i < N; i++) begin
                if (win == i || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 99) < 60);
                    bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        auto_mode = 1'b0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[5] = 32'hA5A5A5A5;
        model_reset();
        #2;
        do_reset();

        // Single requester 0, address 5, four-cycle round trip.
        bus.req_addr[0 +: AW] = 4'd5;
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = '0;
        chk("single_avalid", 64'(bus.mem_r_avalid), 64'(1));
        chk("single_addr", 64'(bus.mem_r_addr), 64'(5));
        repeat (3) cycle();
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0001));
        chk("single_rsp_data", 64'(bus.rsp_data), 64'(32'hA5A5A5A5));
        repeat (3) cycle();

        // All requesters continuously valid from rr_ptr=0.
        do_reset();
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_order", 64'(obs_ready), 64'(1 << (k % N)));
        end
        bus.req_valid = '0;
        repeat (6) cycle();

        // rr_ptr=1 with requesters 0 and 2 -> 2 first, then wrap to 0.
        do_reset();
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = 4'b0101;
        cycle();
        chk("rr_skip_to_2", 64'(obs_ready), 64'(4'b0100));
        bus.req_valid[2] = 1'b0;
        cycle();
        chk("rr_wrap_to_0", 64'(obs_ready), 64'(4'b0001));
        bus.req_valid = '0;
        repeat (6) cycle();

        // Long memory latency: requester 1 streaming fills the tag FIFO.
        mem_lat = 5;
        bus.req_valid = 4'b0010;
        repeat (20) cycle();
        bus.req_valid = '0;
        repeat (10) cycle();
        mem_lat = 2;

        // Orphan return with empty FIFO.
        inj_data = $urandom;
        inj = 1'b1;
        cycle();
        inj = 1'b0;
        repeat (3) cycle();
        chk("orphan_sticky", 64'(err_orphan), 64'(1));
        chk("orphan_no_rsp", 64'(bus.rsp_valid), 64'(0));

        // Random traffic at two memory latencies.
        auto_mode = 1'b1;
        repeat (400) cycle();
        auto_mode = 1'b0;
        bus.req_valid = '0;
        repeat (10) cycle();
        mem_lat = 4;
        auto_mode = 1'b1;
        repeat (300) cycle();
        auto_mode = 1'b0;
        bus.req_valid = '0;
        repeat (10) cycle();
        mem_lat = 2;
`ifdef MEM_RD_ARB_STATS_EN
        chk("stat_grant_model", 64'(stat_grant_cnt), 64'(gcnt));
        chk("stat_stall_model", 64'(stat_stall_cnt), 64'(scnt));
`endif

        // Reset with three reads in flight; nothing may return afterwards.
        bus.req_valid = 4'b1111;
        repeat (3) cycle();
        do_reset();
        repeat (8) cycle();

        // 10 grants and 3 stall cycles.
        mem_lat = 5;
        bus.req_valid = 4'b0001;
        repeat (8) cycle();
        bus.req_valid = '0;
        repeat (10) cycle();
        mem_lat = 2;
        bus.req_valid = 4'b0001;
        repeat (5) cycle();
        bus.req_valid = '0;
        repeat (5) cycle();
`ifdef MEM_RD_ARB_STATS_EN
        chk("stat_grant_10", 64'(stat_grant_cnt), 64'(10));
        chk("stat_stall_3", 64'(stat_stall_cnt), 64'(3));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
